// File: rtl/fetch_decode_stage.sv
// Fetch stage and Fetch/Decode pipeline register for the RV32I pipeline.
// Owns the fetch PC, drives the instruction-memory request/ready handshake,
// selects the next PC (sequential, hold, or redirect from Execute) and
// registers instruction, PC and PC+4 into Decode with stall/flush/bubble.
module fetch_decode_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_F,
   input  logic        stall_D,
   input  logic        flush_D,
   input  logic        pcSrc_E,
   input  logic [31:0] pcTarget_E,
   output logic [31:0] imemAddr,
   output logic        imemReq,
   input  logic [31:0] imemRdata,
   input  logic        imemReady,
   output logic [31:0] instr_D,
   output logic [31:0] pc_D,
   output logic [31:0] pcPlus4_D,
   output logic        valid_D,
   output logic        fetchWait_F
);

   // Fetch-side state
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_F;
   logic [31:0] redirect_pc;
   logic        fetch_done;
   logic        pc_hold;

   // F/D register state
   logic [31:0] instr_q;
   logic [31:0] instr_d;
   logic [31:0] pc_D_q;
   logic [31:0] pc_D_d;
   logic [31:0] pcPlus4_D_q;
   logic [31:0] pcPlus4_D_d;
   logic        valid_q;
   logic        valid_d;

   // Decode-side update selects
   logic        fd_clear;
   logic        fd_hold;

   // Target low bits are dropped: there is no misalignment trap.
   logic        unused_target_bits;
   assign unused_target_bits = ^pcTarget_E[1:0];

   // Request is live whenever reset is not asserted; address is the raw PC.
   assign imemReq     = ~reset;
   assign imemAddr    = pc_q;
   assign fetchWait_F = imemReq & ~imemReady;

   // PC+4 wraps naturally modulo 2^32 (0xFFFF_FFFC -> 0).
   assign pc_plus4_F  = pc_q + 32'd4;
   assign redirect_pc = {pcTarget_E[31:2], 2'b00};

   // A fetch retires only when memory answers and nothing abandons or holds it.
   assign fetch_done  = imemReq & imemReady & ~stall_F & ~pcSrc_E;
   assign pc_hold     = stall_F | ~imemReady;

   // A redirect squashes whatever was being fetched, same as a flush.
   assign fd_clear    = flush_D | pcSrc_E;
   assign fd_hold     = stall_D;

   // Next fetch PC: redirect beats hold beats sequential advance.
   always_comb begin
      pc_d = pc_q;
      if (pcSrc_E) begin
         pc_d = redirect_pc;
      end else if (pc_hold) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_plus4_F;
      end
   end

   // Next F/D contents: clear beats hold beats load; anything else is a bubble.
   always_comb begin
      instr_d     = NOP_INSTR;
      pc_D_d      = 32'd0;
      pcPlus4_D_d = 32'd0;
      valid_d     = 1'b0;
      if (fd_clear) begin
         instr_d     = NOP_INSTR;
         pc_D_d      = 32'd0;
         pcPlus4_D_d = 32'd0;
         valid_d     = 1'b0;
      end else if (fd_hold) begin
         instr_d     = instr_q;
         pc_D_d      = pc_D_q;
         pcPlus4_D_d = pcPlus4_D_q;
         valid_d     = valid_q;
      end else if (fetch_done) begin
         instr_d     = imemRdata;
         pc_D_d      = pc_q;
         pcPlus4_D_d = pc_plus4_F;
         valid_d     = 1'b1;
      end
   end

   // Fetch PC register; reset takes effect immediately, abandoning any fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // F/D pipeline register; reset leaves a bubble in Decode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q     <= NOP_INSTR;
         pc_D_q      <= 32'd0;
         pcPlus4_D_q <= 32'd0;
         valid_q     <= 1'b0;
      end else begin
         instr_q     <= instr_d;
         pc_D_q      <= pc_D_d;
         pcPlus4_D_q <= pcPlus4_D_d;
         valid_q     <= valid_d;
      end
   end

   assign instr_D   = instr_q;
   assign pc_D      = pc_D_q;
   assign pcPlus4_D = pcPlus4_D_q;
   assign valid_D   = valid_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage: directed scenarios followed by
// randomized hazard/memory/redirect traffic, compared against a reference model.
module tb_fetch_decode_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        stall_F;
   logic        stall_D;
   logic        flush_D;
   logic        pcSrc_E;
   logic [31:0] pcTarget_E;
   logic [31:0] imemAddr;
   logic        imemReq;
   logic [31:0] imemRdata;
   logic        imemReady;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic [31:0] pcPlus4_D;
   logic        valid_D;
   logic        fetchWait_F;

   // Memory returns a word derived from the address it is asked for.
   logic [31:0] mem_xor;
   assign imemRdata = imemAddr ^ mem_xor;

   int checks;
   int failures;

   // Reference model: what Fetch is pointing at and what Decode holds.
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pcd;
   logic [31:0] m_pc4;
   logic        m_valid;

   fetch_decode_stage #(
      .RESET_PC (RESET_PC),
      .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stall_F    (stall_F),
      .stall_D    (stall_D),
      .flush_D    (flush_D),
      .pcSrc_E    (pcSrc_E),
      .pcTarget_E (pcTarget_E),
      .imemAddr   (imemAddr),
      .imemReq    (imemReq),
      .imemRdata  (imemRdata),
      .imemReady  (imemReady),
      .instr_D    (instr_D),
      .pc_D       (pc_D),
      .pcPlus4_D  (pcPlus4_D),
      .valid_D    (valid_D),
      .fetchWait_F(fetchWait_F)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = RESET_PC;
      m_instr = NOP_INSTR;
      m_pcd   = 32'd0;
      m_pc4   = 32'd0;
      m_valid = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".imemAddr"},    imemAddr,    m_pc);
      chk({tag, ".imemReq"},     {31'd0, imemReq},     {31'd0, ~reset});
      chk({tag, ".fetchWait_F"}, {31'd0, fetchWait_F}, {31'd0, ~reset & ~imemReady});
      chk({tag, ".instr_D"},     instr_D,     m_instr);
      chk({tag, ".pc_D"},        pc_D,        m_pcd);
      chk({tag, ".pcPlus4_D"},   pcPlus4_D,   m_pc4);
      chk({tag, ".valid_D"},     {31'd0, valid_D},     {31'd0, m_valid});
   endtask

   // One clock: check combinational outputs under the current inputs, predict
   // the state after the edge, take the edge, then check everything.
   task automatic cycle(input string tag);
      logic [31:0] n_pc, n_instr, n_pcd, n_pc4;
      logic        n_valid;
      logic        fetched;
      #2;
      check_all({tag, "/pre"});
      n_pc = m_pc; n_instr = m_instr; n_pcd = m_pcd; n_pc4 = m_pc4; n_valid = m_valid;
      if (!reset) begin
         fetched = imemReady && !stall_F && !pcSrc_E;
         if (flush_D || pcSrc_E || (!stall_D && !fetched)) begin
            n_instr = NOP_INSTR; n_pcd = 32'd0; n_pc4 = 32'd0; n_valid = 1'b0;
         end else if (!stall_D) begin
            n_instr = m_pc ^ mem_xor; n_pcd = m_pc; n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
         end
         if (pcSrc_E)                      n_pc = pcTarget_E & 32'hFFFF_FFFC;
         else if (stall_F || !imemReady)   n_pc = m_pc;
         else                              n_pc = m_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_pc4 = n_pc4; m_valid = n_valid;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0;
      pcSrc_E = 1'b0; pcTarget_E = 32'd0; imemReady = 1'b1;
   endtask

   task automatic redirect(input logic [31:0] tgt, input string tag);
      pcSrc_E = 1'b1; pcTarget_E = tgt;
      cycle(tag);
      pcSrc_E = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      mem_xor  = 32'd0;
      reset    = 1'b1;
      idle_inputs();
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset.instr_nop", instr_D, NOP_INSTR);

      // 1: sequential fetch, word == address
      reset = 1'b0;
      cycle("seq0");
      chk("seq0.pc_D", pc_D, 32'h0);
      chk("seq0.pcPlus4_D", pcPlus4_D, 32'h4);
      chk("seq0.valid_D", {31'd0, valid_D}, 32'd1);
      chk("seq0.imemAddr", imemAddr, 32'h4);
      repeat (3) cycle("seq");
      chk("seq.imemAddr10", imemAddr, 32'h10);

      // 2: load-use stall for one cycle at pc_F=0x10
      stall_F = 1'b1; stall_D = 1'b1;
      cycle("loaduse");
      chk("loaduse.imemAddr", imemAddr, 32'h10);
      chk("loaduse.pc_D", pc_D, 32'h0C);
      chk("loaduse.valid_D", {31'd0, valid_D}, 32'd1);
      stall_F = 1'b0; stall_D = 1'b0;
      cycle("resume");
      chk("resume.pc_D", pc_D, 32'h10);
      repeat (3) cycle("seq2");
      chk("seq2.imemAddr20", imemAddr, 32'h20);

      // 3: redirect to misaligned target
      redirect(32'h0000_0103, "redir");
      chk("redir.imemAddr", imemAddr, 32'h100);
      chk("redir.valid_D", {31'd0, valid_D}, 32'd0);
      chk("redir.instr_D", instr_D, NOP_INSTR);
      cycle("redir_next");
      chk("redir_next.pc_D", pc_D, 32'h100);

      // 4: memory wait three cycles at 0x40
      redirect(32'h40, "to40");
      imemReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle("memwait");
         chk("memwait.imemAddr", imemAddr, 32'h40);
         chk("memwait.fetchWait_F", {31'd0, fetchWait_F}, 32'd1);
         chk("memwait.valid_D", {31'd0, valid_D}, 32'd0);
      end
      imemReady = 1'b1;
      cycle("memdone");
      chk("memdone.pc_D", pc_D, 32'h40);
      chk("memdone.valid_D", {31'd0, valid_D}, 32'd1);

      // 5: stall_D with flush_D -> flush wins; then wrap at 0xFFFF_FFFC
      stall_D = 1'b1; flush_D = 1'b1;
      cycle("stallflush");
      chk("stallflush.valid_D", {31'd0, valid_D}, 32'd0);
      chk("stallflush.instr_D", instr_D, NOP_INSTR);
      stall_D = 1'b0; flush_D = 1'b0;
      redirect(32'hFFFF_FFFC, "toTop");
      cycle("wrap");
      chk("wrap.pc_D", pc_D, 32'hFFFF_FFFC);
      chk("wrap.pcPlus4_D", pcPlus4_D, 32'h0);
      chk("wrap.imemAddr", imemAddr, 32'h0);

      // 6: asynchronous reset mid-cycle at pc_F=0x80 with valid_D=1
      redirect(32'h7C, "to7C");
      cycle("at80");
      chk("at80.imemAddr", imemAddr, 32'h80);
      chk("at80.valid_D", {31'd0, valid_D}, 32'd1);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
      cycle("rst_hold");
      reset = 1'b0;
      cycle("rst_release");
      chk("rst_release.pc_D", pc_D, RESET_PC);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         if (n % 50 == 0) mem_xor = $urandom;
         idle_inputs();
         if ($urandom_range(0, 7) == 0) begin
            stall_F = 1'b1; stall_D = 1'b1;
         end else begin
            stall_F = ($urandom_range(0, 15) == 0);
            stall_D = ($urandom_range(0, 15) == 0);
         end
         flush_D    = ($urandom_range(0, 15) == 0);
         pcSrc_E    = ($urandom_range(0, 9) == 0);
         pcTarget_E = $urandom;
         imemReady  = ($urandom_range(0, 3) != 0);
         reset      = ($urandom_range(0, 59) == 0);
         if (reset) model_reset();
         cycle("rand");
      end
      reset = 1'b0;
      idle_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
